// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: mode encodings and the
// direction flag used by the bounce and fill patterns.
package led_pattern_pkg;

  // Pattern select encodings driven on the mode port
  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  // Direction flag: LEFT means moving up (bounce) or growing (fill),
  // RIGHT means moving down (bounce) or shrinking (fill).
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// Enable-gated prescaler: produces a one-cycle tick every divisor+1 enabled
// cycles. The >= compare means that lowering divisor below the running count
// fires on the very next enabled cycle instead of wrapping around.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [DIV_W-1:0] count;

  // Tick is combinational so the pattern register sees it on the same edge
  // that clears the count.
  assign tick = enable && (count >= divisor);

  // Count enabled cycles; restart on tick, on load (clear) and on reset
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (tick) begin
        count <= '0;
      end else begin
        count <= count + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left, rotate-right, bounce and fill patterns
// stepped by a prescaled tick. Load replaces the pattern at any time and wins
// over a simultaneous tick; reset wins over everything.
module led_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] divisor,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] diode,
  output logic             step
);

  import led_pattern_pkg::*;

  localparam logic [WIDTH-1:0] PAT_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_THREE = WIDTH'(3);

  logic             tick;
  logic [WIDTH-1:0] pat_nxt;
  dir_t             dir;
  dir_t             dir_nxt;

  // Rotate one position towards the MSB, wrapping the MSB into bit 0
  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Rotate one position towards the LSB, wrapping bit 0 into the MSB
  function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] v);
    return {v[0], v[WIDTH-1:1]};
  endfunction

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .clear   (load),
    .divisor (divisor),
    .tick    (tick)
  );

  // Next pattern and direction for the currently selected mode; only the
  // end bits steer bounce, so multi-bit patterns move as a block.
  always_comb begin
    pat_nxt = diode;
    dir_nxt = dir;
    case (mode)
      MODE_ROL: pat_nxt = rol1(diode);
      MODE_ROR: pat_nxt = ror1(diode);
      MODE_BOUNCE: begin
        if (dir == DIR_LEFT) begin
          if (diode[WIDTH-1]) begin
            pat_nxt = diode >> 1;
            dir_nxt = DIR_RIGHT;
          end else begin
            pat_nxt = diode << 1;
          end
        end else begin
          if (diode[0]) begin
            pat_nxt = diode << 1;
            dir_nxt = DIR_LEFT;
          end else begin
            pat_nxt = diode >> 1;
          end
        end
      end
      default: begin
        if (dir == DIR_LEFT) begin
          if (&diode) begin
            pat_nxt = diode >> 1;
            dir_nxt = DIR_RIGHT;
          end else begin
            pat_nxt = (diode << 1) | PAT_ONE;
          end
        end else begin
          if (diode == PAT_ONE) begin
            pat_nxt = PAT_THREE;
            dir_nxt = DIR_LEFT;
          end else begin
            pat_nxt = diode >> 1;
          end
        end
      end
    endcase
  end

  // Pattern, direction and step registers: reset, then load, then tick
  always_ff @(posedge clock) begin
    if (reset) begin
      diode <= PAT_ONE;
      dir   <= DIR_LEFT;
      step  <= 1'b0;
    end else if (load) begin
      diode <= load_value;
      dir   <= DIR_LEFT;
      step  <= 1'b0;
    end else if (tick) begin
      diode <= pat_nxt;
      dir   <= dir_nxt;
      step  <= 1'b1;
    end else begin
      step  <= 1'b0;
    end
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, number of LED outputs (minimum 2); DIV_W, default 24, prescaler counter and divisor width.
REQ-002 Port clock SHALL be input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit: reset is synchronous and active-high.
REQ-004 Port enable SHALL be input, 1 bit: high lets the prescaler count and the pattern advance.
REQ-005 Port mode SHALL be input, 2 bits: pattern select (00 rotate-left, 01 rotate-right, 10 bounce, 11 fill).
REQ-006 Port divisor SHALL be input, DIV_W bits: one pattern step every divisor+1 enabled cycles.
REQ-007 Port load SHALL be input, 1 bit: one-cycle request to replace the pattern with load_value.
REQ-008 Port load_value SHALL be input, WIDTH bits: pattern written on load.
REQ-009 Port diode SHALL be output, WIDTH bits, registered: current LED pattern.
REQ-010 Port step SHALL be output, 1 bit, registered: high for one cycle whenever diode advances due to a tick.

Function
REQ-011 Prescaler count SHALL increment on each enabled cycle; tick occurs when enable=1 and count>=divisor; count returns to 0 on that edge.
REQ-012 The >= compare SHALL make a divisor reduced below the current count produce a tick on the next enabled cycle.
REQ-013 With divisor=0 and enable=1, the block SHALL produce a tick on every cycle.
REQ-014 When enable=0, count, diode and direction SHALL hold, and step SHALL be 0.
REQ-015 Rotate-left: on tick, diode[i] <= diode[i-1] and diode[0] <= diode[WIDTH-1].
REQ-016 Rotate-right: on tick, diode[i] <= diode[i+1] and diode[WIDTH-1] <= diode[0].
REQ-017 Bounce uses a direction flag dir (0=left, 1=right). On tick: dir=0 and diode[WIDTH-1]=1 -> shift right, set dir=1; dir=0 otherwise -> shift left, zero fill. dir=1 and diode[0]=1 -> shift left, set dir=0; dir=1 otherwise -> shift right, zero fill.
REQ-018 Fill uses the same dir flag (0=grow, 1=shrink). On tick: grow with diode all ones -> diode>>1, dir=1; grow otherwise -> (diode<<1)|1. Shrink with diode==1 -> diode=3, dir=0; shrink otherwise -> diode>>1. From reset this yields the sequence 1,3,7,...,all-ones,...,3,1,3.
REQ-019 An all-zero pattern SHALL remain all-zero in every mode; in fill mode it SHALL advance to 1.
REQ-020 A mode change SHALL take effect at the next tick; diode and dir SHALL be kept across the change, with no other side effect.
REQ-021 Load SHALL win over a tick in the same cycle: diode <= load_value, count <= 0, dir <= 0, step <= 0; this applies regardless of enable.
REQ-022 Rotate and bounce modes SHALL accept patterns with several bits set; bounce direction decisions SHALL use only the end bits as defined in REQ-017.
REQ-023 step SHALL be asserted in the same cycle the new diode value first appears, so latency is one edge from the tick condition.

Reset
REQ-024 While reset=1 at a clock edge, the block SHALL set diode=1 (LSB only), count=0, dir=0, step=0.
REQ-025 Reset SHALL override load and enable.
REQ-026 A reset asserted mid-pattern SHALL discard all progress; the first post-reset tick SHALL occur on the (divisor+1)th enabled edge after reset deasserts.

Structure
REQ-027 Mode encodings SHALL be constants in the shared package led_pattern_pkg: MODE_ROL, MODE_ROR, MODE_BOUNCE, MODE_FILL.
REQ-028 The prescaler (count, compare, tick, clear on load) SHALL be a sub-module led_prescaler, parametrised by DIV_W.
REQ-029 Pattern next-state logic and the dir flag SHALL live in led_pattern_gen.

Verification
REQ-030 WIDTH=8, divisor=0, mode=00, enable=1 after reset -> diode 01,02,04,...,80,01 on successive cycles, with step high every cycle.
REQ-031 WIDTH=8, divisor=3, mode=01 -> diode changes 01->80->40 on every 4th edge; step is high for exactly one cycle per change.
REQ-032 WIDTH=8, mode=10, divisor=0 -> 01,02,...,80,40,...,01,02: 14-step period with no repeat at the ends.
REQ-033 WIDTH=8, mode=11, divisor=0 -> 01,03,07,...,FF,7F,...,03,01,03.
REQ-034 Load with load_value=0x81 in the same cycle as a tick -> diode=81, step=0, next tick after divisor+1 cycles; mode=00 then gives 03.
REQ-035 Reset asserted during bounce at diode=20 with dir=1, then released with divisor=2 -> diode=01 and first advance to 02 on the 3rd enabled edge; enable low for 5 cycles -> diode and step frozen.
